// File: rtl/et2_pkg.sv
// Shared types and configuration helpers for the segment-serial ET2 adder.
package et2_pkg;

  localparam int unsigned ET2_WIDTH = 32;
  localparam int unsigned ET2_SEG   = 4;
  localparam int unsigned ET2_NSEG  = ET2_WIDTH / ET2_SEG;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } et2_state_e;

  function automatic int unsigned seg_idx_width(input int unsigned nseg);
    return (nseg <= 1) ? 1 : $clog2(nseg);
  endfunction

  function automatic logic seg_cfg_ok(input int unsigned width, input int unsigned seg);
    return (seg != 0) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/et2_segment_unit.sv
// One SEG-bit ripple segment: sum, true carry-out and predicted (cin = 0) carry-out.
module et2_segment_unit #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           pcout_o
);

  logic [SEG:0] full;
  logic [SEG:0] part;

  assign full    = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};
  assign part    = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o   = full[SEG-1:0];
  assign cout_o  = full[SEG];
  assign pcout_o = part[SEG];

endmodule

// File: rtl/et2_serial_adder_ctrl.sv
// Segment-serial error-tolerant type-2 adder: one segment unit reused over NSEG cycles.
// Optional ET2_ERR_FLAG_EN adds err_o, flagging approximate-mode carry mispredictions.
module et2_serial_adder_ctrl
  import et2_pkg::*;
#(
  parameter int unsigned WIDTH = ET2_WIDTH,
  parameter int unsigned SEG   = ET2_SEG,
  parameter logic        CIN0  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             exact_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o,
  output logic             busy_o
`ifdef ET2_ERR_FLAG_EN
  ,
  output logic             err_o
`endif
);

  localparam int unsigned NSEG = WIDTH / SEG;
  localparam int unsigned IW   = seg_idx_width(NSEG);
  localparam logic [IW-1:0] LAST = IW'(NSEG - 1);

  if (!seg_cfg_ok(WIDTH, SEG)) begin : g_cfg_err
    $error("et2_serial_adder_ctrl: WIDTH must be a non-zero multiple of SEG");
  end

  et2_state_e       state_q, state_d;
  logic [IW-1:0]    seg_idx_q, seg_idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             exact_q, exact_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   res_q, res_d;

  logic [31:0]      lsb;
  logic [SEG-1:0]   seg_a, seg_b, seg_sum;
  logic             seg_cout, seg_pcout, nxt_carry;

  assign lsb   = 32'(seg_idx_q) * SEG;
  assign seg_a = SEG'(a_q >> lsb);
  assign seg_b = SEG'(b_q >> lsb);

  et2_segment_unit #(.SEG(SEG)) u_seg (
    .a_i     (seg_a),
    .b_i     (seg_b),
    .cin_i   (carry_q),
    .sum_o   (seg_sum),
    .cout_o  (seg_cout),
    .pcout_o (seg_pcout)
  );

  assign nxt_carry = exact_q ? seg_cout : seg_pcout;

  always_comb begin
    state_d   = state_q;
    seg_idx_d = seg_idx_q;
    a_d       = a_q;
    b_d       = b_q;
    exact_d   = exact_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    res_d     = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d       = add1_i;
          b_d       = add2_i;
          exact_d   = exact_i;
          sum_d     = '0;
          carry_d   = CIN0;
          seg_idx_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        // Sum register is cleared on accept, so OR-ing the slice in is enough.
        sum_d   = sum_q | (WIDTH'(seg_sum) << lsb);
        carry_d = nxt_carry;
        if (seg_idx_q == LAST) begin
          res_d   = {nxt_carry, sum_d};
          state_d = DONE;
        end else begin
          seg_idx_d = seg_idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      seg_idx_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      exact_q   <= 1'b0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      seg_idx_q <= seg_idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      exact_q   <= exact_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      res_q     <= res_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign result_o    = res_q;

`ifdef ET2_ERR_FLAG_EN
  logic xc_q, xc_d;
  logic mis_q, mis_d;
  logic err_q, err_d;
  logic x_cout;

  // Exact carry without a second adder: carry = generate | (all-propagate & cin).
  assign x_cout = seg_pcout | (((seg_a ^ seg_b) == '1) & xc_q);

  always_comb begin
    xc_d  = xc_q;
    mis_d = mis_q;
    err_d = err_q;
    if (state_q == IDLE && in_valid_i) begin
      xc_d  = CIN0;
      mis_d = 1'b0;
      err_d = 1'b0;
    end else if (state_q == RUN) begin
      xc_d  = x_cout;
      mis_d = mis_q | (nxt_carry != x_cout);
      if (seg_idx_q == LAST) err_d = !exact_q && mis_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xc_q  <= 1'b0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      xc_q  <= xc_d;
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_et2_serial_adder_ctrl.sv
// Directed self-checking bench for et2_serial_adder_ctrl (default WIDTH=32, SEG=4, CIN0=1).
module tb_et2_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] add1 = '0;
  logic [31:0] add2 = '0;
  logic        exact = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [32:0] result;
  logic        busy;
`ifdef ET2_ERR_FLAG_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  et2_serial_adder_ctrl #(.WIDTH(32), .SEG(4), .CIN0(1'b1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .add1_i      (add1),
    .add2_i      (add2),
    .exact_i     (exact),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .busy_o      (busy)
`ifdef ET2_ERR_FLAG_EN
    ,
    .err_o       (err)
`endif
  );

  // Accept one operand pair, scramble inputs after accept, and wait for out_valid.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic ex,
                        output int lat, output logic [32:0] res);
    add1 = a; add2 = b; exact = ex; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    add1 = ~a; add2 = a ^ b; exact = ~ex;
    lat = 999;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    res = result;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [32:0] res;
    rst = 1'b1;
    #12;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (result !== 33'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_txn(32'h12345678, 32'h11111111, 1'b1, lat, res);
    n_checks++; if (res !== 33'h0_2345678A) begin n_fail++; $display("FAIL pre_reset_txn got %h want 02345678a", res); end
    release_result();
    // start a new transaction, then abort it with an asynchronous reset mid-RUN
    add1 = 32'hDEADBEEF; add2 = 32'h01010101; exact = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_busy got %b want 0", busy); end
    n_checks++; if (result !== 33'h0) begin n_fail++; $display("FAIL midrun_reset_result got %h want 0", result); end
`ifdef ET2_ERR_FLAG_EN
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_err got %b want 0", err); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_txn(32'hDEADBEEF, 32'h01010101, 1'b1, lat, res);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL post_reset_latency got %0d want 8", lat); end
    n_checks++; if (res !== 33'h0_DFAEBFF1) begin n_fail++; $display("FAIL post_reset_txn got %h want 0dfaebff1", res); end
    release_result();
  endtask

  task automatic test_approx_miss();
    int lat; logic [32:0] res;
    do_txn(32'h0000000F, 32'h00000000, 1'b0, lat, res);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL approx_miss_latency got %0d want 8", lat); end
    n_checks++; if (res !== 33'h0_00000000) begin n_fail++; $display("FAIL approx_miss_result got %h want 000000000", res); end
`ifdef ET2_ERR_FLAG_EN
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL approx_miss_err got %b want 1", err); end
`endif
    release_result();
  endtask

  task automatic test_exact();
    int lat; logic [32:0] res;
    do_txn(32'h0000000F, 32'h00000000, 1'b1, lat, res);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL exact_latency got %0d want 8", lat); end
    n_checks++; if (res !== 33'h0_00000010) begin n_fail++; $display("FAIL exact_result got %h want 000000010", res); end
`ifdef ET2_ERR_FLAG_EN
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL exact_err got %b want 0", err); end
`endif
    release_result();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL exact_idle_in_ready got %b want 1", in_ready); end
    n_checks++; if (result !== 33'h0_00000010) begin n_fail++; $display("FAIL exact_result_held_idle got %h want 000000010", result); end
  endtask

  task automatic test_long_chain();
    int lat; logic [32:0] res;
    do_txn(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, res);
    n_checks++; if (res !== 33'h0_FFFFFF01) begin n_fail++; $display("FAIL long_chain_approx got %h want 0ffffff01", res); end
`ifdef ET2_ERR_FLAG_EN
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL long_chain_approx_err got %b want 1", err); end
`endif
    release_result();
    do_txn(32'hFFFFFFFF, 32'h00000001, 1'b1, lat, res);
    n_checks++; if (res !== 33'h1_00000001) begin n_fail++; $display("FAIL long_chain_exact got %h want 100000001", res); end
    release_result();
  endtask

  task automatic test_pred_ok();
    int lat; logic [32:0] res;
    do_txn(32'h0000000F, 32'h00000001, 1'b0, lat, res);
    n_checks++; if (res !== 33'h0_00000011) begin n_fail++; $display("FAIL pred_ok_approx got %h want 000000011", res); end
`ifdef ET2_ERR_FLAG_EN
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL pred_ok_err got %b want 0", err); end
`endif
    release_result();
    do_txn(32'h0000000F, 32'h00000001, 1'b1, lat, res);
    n_checks++; if (res !== 33'h0_00000011) begin n_fail++; $display("FAIL pred_ok_exact got %h want 000000011", res); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat; logic [32:0] res;
    do_txn(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b1, lat, res);
    n_checks++; if (res !== 33'h0_B4B4B4B5) begin n_fail++; $display("FAIL bp_first_result got %h want 0b4b4b4b5", res); end
    // hold off the consumer while a new request is waiting
    add1 = 32'hFFFFFFFF; add2 = 32'h00000001; exact = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 33'h0_B4B4B4B5) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got valid=%b ready=%b result=%h want valid=1 ready=0 result=0b4b4b4b5",
                 i, out_valid, in_ready, result);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got ready=%b valid=%b busy=%b want ready=1 valid=0 busy=0", in_ready, out_valid, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept got busy=%b ready=%b want busy=1 ready=0", busy, in_ready);
    end
    lat = 999;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL b2b_latency got %0d want 8", lat); end
    n_checks++; if (result !== 33'h1_00000001) begin n_fail++; $display("FAIL b2b_result got %h want 100000001", result); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_approx_miss();
    test_exact();
    test_long_chain();
    test_pred_ok();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/et2_serial_adder_ctrl.md
Name: et2_serial_adder_ctrl

Overview:
- Segment-serial sequencer for the 32-bit error-tolerant type-2 adder.
- Reuses one SEG-bit segment unit across NSEG = WIDTH/SEG cycles instead of instantiating NSEG copies. The segment unit is a SEG-bit ripple-carry adder plus a carry predictor.
- Operands enter, and results leave, through valid/ready handshakes.
- Per transaction, the adder runs in approximate mode (predicted segment carries) or exact mode (true ripple carry).
- Used where area matters more than throughput.

Parameters:
- WIDTH, 32, operand width; must be a multiple of SEG.
- SEG, 4, segment width in bits.
- CIN0, 1, carry-in of segment 0 in both modes.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  operand request.
- in_ready_o  out  1  block can accept operands.
- add1_i  in  WIDTH  operand A.
- add2_i  in  WIDTH  operand B.
- exact_i  in  1  1 = exact carry chain, 0 = approximate.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  WIDTH+1  {carry_out, sum}.
- busy_o  out  1  transaction in flight (state != IDLE).

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values: state = IDLE, seg_idx = 0, in_ready_o = 1, out_valid_o = 0, busy_o = 0, result_o = 0, internal carry registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i && in_ready_o: latch add1_i, add2_i and exact_i; clear the sum register; carry register = CIN0; seg_idx = 0; go to RUN.
- RUN (one segment per cycle, segment k = bits [k*SEG+SEG-1 : k*SEG]):
  - sum_k = (a_k + b_k + cin_k) mod 2^SEG, written into the sum register slice k.
  - Exact mode: cin_(k+1) = true carry-out of segment k.
  - Approximate mode: cin_(k+1) = carry-out of (a_k + b_k) with carry-in 0, i.e. the predicted carry. It does not depend on cin_k.
  - cin_0 = CIN0 in both modes.
  - When seg_idx = NSEG-1: result bit WIDTH = cin_NSEG (exact: true carry; approximate: predicted carry of the top segment); go to DONE.
  - Otherwise seg_idx increments.
- DONE:
  - out_valid_o = 1; result_o is held stable and in_ready_o = 0.
  - On out_ready_i: go to IDLE. in_ready_o returns the following cycle; no same-cycle re-accept.
- Latency: accept edge, then NSEG RUN cycles. out_valid_o rises on the edge that ends the last RUN cycle. Default: 8 cycles from accept to out_valid_o.
- Throughput: at best one transaction per NSEG+2 cycles.
- result_o may change only on entry to DONE or on reset. It holds its value through IDLE until the next DONE.
- Inputs are ignored outside IDLE, including in_valid_i, operand changes and exact_i.
- out_ready_i asserted outside DONE has no effect.
- Reset asserted mid-transaction aborts immediately; all outputs return to reset values and no partial result is emitted.
- seg_idx width = clog2(NSEG), minimum 1. The counter never wraps past NSEG-1.

Optional Feature:
- Macro: ET2_ERR_FLAG_EN.
- With the macro defined:
  - Extra output err_o (1 bit, reset 0).
  - An exact carry chain is always tracked in parallel, whatever exact_i is.
  - err_o is set in DONE when, in approximate mode, any cin_k (k = 1..NSEG) differs from the exact-chain carry.
  - err_o is always 0 in exact mode.
  - err_o is cleared on accepting a new transaction.
- Without the macro: no err_o port and no parallel carry chain.

Decomposition:
- Package et2_pkg: state enum (IDLE/RUN/DONE), localparam NSEG = WIDTH/SEG, seg_idx width function, elaboration check WIDTH % SEG == 0.
- One combinational sub-module, et2_segment_unit.
  - Inputs: SEG-bit a, SEG-bit b, cin.
  - Outputs: sum, true carry-out, predicted carry-out.
- The controller holds the FSM, operand and sum registers, and the slice mux.

Test Plan:
- Reset: assert rst_i mid-RUN -> out_valid_o = 0, in_ready_o = 1, busy_o = 0, result_o = 0 asynchronously; the next transaction completes normally.
- Approx carry miss: A = 0x0000000F, B = 0x00000000, exact_i = 0 -> result_o = 0x0_00000000 after 8 cycles; err_o = 1 if enabled.
- Exact, same operands: A = 0x0000000F, B = 0x00000000, exact_i = 1 -> result_o = 0x0_00000010; err_o = 0.
- Long chain: A = 0xFFFFFFFF, B = 0x00000001.
  - exact_i = 0 -> 0x0_FFFFFF01.
  - exact_i = 1 -> 0x1_00000001.
- Predicted carry correct: A = 0x0000000F, B = 0x00000001, exact_i = 0 -> 0x0_00000011, identical to exact mode; err_o = 0.
- Backpressure: hold out_ready_i = 0 for 5 cycles in DONE -> result_o stable, in_ready_o = 0, in_valid_i ignored. Release -> IDLE the next cycle, then a back-to-back transaction is accepted.
